halflife_input_cond: RTL and testbench
======================================

# halflife_input_cond

Input conditioner that sits directly upstream of the half-life timer core. It turns the raw, bouncing `up`, `down` and `load` push-button pins into clean single-cycle command pulses: synchronise, debounce, detect the rising edge, then auto-repeat while `up`/`down` is held. The core then sees at most one command per cycle and never sees contradictory up+down commands.

## Interface
Parameters:
- `DEBOUNCE`, default 1000: consecutive stable synchronised samples required to accept a level change (≥1).
- `REPEAT_DELAY`, default 50000: cycles from the first pulse to the first auto-repeat pulse (≥2).
- `REPEAT_RATE`, default 10000: cycles between auto-repeat pulses (≥2).
- `CNT_W`, default 16: width of all internal counters; each parameter must be < 2^CNT_W.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `up_raw` in 1: raw up button, asynchronous.
- `down_raw` in 1: raw down button, asynchronous.
- `load_raw` in 1: raw load button, asynchronous.
- `up_pulse` out 1: one-cycle increment command.
- `down_pulse` out 1: one-cycle decrement command.
- `load_pulse` out 1: one-cycle load command (no repeat).
- `up_level`, `down_level`, `load_level` out 1 each: debounced button levels.

## Operation
- Each channel has a 2-flop synchroniser, a debouncer and an edge/repeat FSM.
- Debouncer:
  - The counter clears whenever the synchronised sample equals the debounced level.
  - Otherwise the counter increments. When it reaches `DEBOUNCE`, the level flips and the counter clears.
  - A bounce shorter than `DEBOUNCE` cycles is ignored.
- Up/down FSM states: IDLE, DELAY, REPEAT.
  - IDLE → DELAY on a debounced rise. Emit a pulse, load the timer with `REPEAT_DELAY`.
  - DELAY: decrement the timer. At 1, emit a pulse, reload with `REPEAT_RATE`, go to REPEAT.
  - REPEAT: decrement. At 1, emit a pulse and reload `REPEAT_RATE`.
  - In DELAY or REPEAT, a debounced fall returns the FSM to IDLE immediately with no pulse that cycle.
- Load channel: same FSM with repeat disabled. It emits one pulse on a debounced rise and then waits in DELAY until the debounced fall.
- Arbitration:
  - While `up_level` and `down_level` are both 1, `up_pulse` and `down_pulse` are both forced to 0. The FSMs keep counting.
  - `load_pulse` has priority: in any cycle where `load_pulse`=1, `up_pulse` and `down_pulse` are forced to 0.
- Outputs are registered; pulses are never wider than one cycle.

## Timing
- Reset values: all outputs 0, synchronisers 0, counters 0, FSMs in IDLE.
- Reset takes effect immediately on assertion. Releasing it mid-press does not emit a pulse until the debounced level has risen from 0.
- Press latency, from the first `clk` edge that samples `raw`=1 on a clean step:
  - 2 cycles of synchronisation, plus `DEBOUNCE` cycles for the level flip, plus 1 cycle for the registered pulse.
  - The `*_level` output rises 1 cycle before the first pulse.
- Repeat timing: the second pulse comes exactly `REPEAT_DELAY` cycles after the first. Later pulses are every `REPEAT_RATE` cycles.
- Release latency: 2 + `DEBOUNCE` cycles until `*_level` falls. No pulse occurs on release.
- A simultaneous rise of up and down produces no pulses. If one button is released first, the remaining button resumes its repeat cadence; no fresh initial pulse is emitted.
- Counters never wrap: the timer reload happens on the terminal cycle, and the debounce counter saturates at `DEBOUNCE`.

## Structure
- `halflife_pkg` holds:
  - the FSM state enum (IDLE, DELAY, REPEAT);
  - the default `DEBOUNCE`, `REPEAT_DELAY` and `REPEAT_RATE` constants.
- Sub-module `halflife_btn_chan` contains the synchroniser, debouncer and FSM.
  - Parameter `REPEAT_EN` selects auto-repeat.
  - Ports: `clk`, `reset`, `raw`, `level`, `pulse`.
- The top instantiates `halflife_btn_chan` three times (load with `REPEAT_EN`=0) and adds the arbitration logic.

## Test plan
Use `DEBOUNCE`=4, `REPEAT_DELAY`=10, `REPEAT_RATE`=5.
- Clean `up_raw` step held for 30 cycles → `up_level` rises 6 cycles after the sampling edge, `up_pulse` at cycle 7. Repeats at cycles 17, 22 and 27. No pulse on release.
- `down_raw` bounce pattern 1,0,1,1,0 followed by a steady 1 → exactly one `down_pulse`, timed from the start of the stable run.
- `load_raw` held for 40 cycles → exactly one `load_pulse`. `up_raw` pressed on the same cycle → `up_pulse` suppressed on the `load_pulse` cycle only.
- `up_raw` and `down_raw` rise on the same cycle, held for 20 cycles, then `down_raw` released → no pulses while both are high. `up_pulse` resumes on the 5-cycle cadence afterwards.
- `reset` asserted mid-REPEAT → all outputs 0 immediately. After release with `up_raw` still high → first pulse 2+4+1 cycles later.
- A 3-cycle glitch on `up_raw` (shorter than `DEBOUNCE`) → no level change and no pulse.

Source files
------------

// File: rtl/halflife_pkg.sv
// Shared types and default timing constants for the half-life timer input conditioner.
package halflife_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  localparam int DEF_DEBOUNCE     = 1000;
  localparam int DEF_REPEAT_DELAY = 50000;
  localparam int DEF_REPEAT_RATE  = 10000;
  localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/halflife_btn_chan.sv
// One push-button channel: synchroniser, debouncer and edge/auto-repeat FSM.
// Emits a registered single-cycle pulse on each accepted press and repeat tick.
module halflife_btn_chan
  import halflife_pkg::*;
#(
  parameter int DEBOUNCE     = DEF_DEBOUNCE,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int CNT_W        = DEF_CNT_W,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] DLY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_C = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] deb_cnt_r;
  logic [CNT_W-1:0] deb_cnt_s;
  logic             level_r;
  logic             level_s;
  btn_state_e       state_r;
  btn_state_e       state_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_s;
  logic             pulse_r;
  logic             pulse_s;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce next-state: the counter saturates at DEBOUNCE, so the level flips on the cycle after it gets there.
  always_comb begin
    deb_cnt_s = deb_cnt_r;
    level_s   = level_r;
    if (sync2_r == level_r) begin
      deb_cnt_s = '0;
    end else if (deb_cnt_r >= DEB_C) begin
      deb_cnt_s = '0;
      level_s   = ~level_r;
    end else begin
      deb_cnt_s = deb_cnt_r + ONE_C;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt_r <= '0;
      level_r   <= 1'b0;
    end else begin
      deb_cnt_r <= deb_cnt_s;
      level_r   <= level_s;
    end
  end

  // Edge/repeat FSM next-state; a fall always wins over a terminal timer tick.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    pulse_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (level_r) begin
          pulse_s = 1'b1;
          state_s = ST_DELAY;
          timer_s = REPEAT_EN ? DLY_C : '0;
        end else begin
          state_s = ST_IDLE;
          timer_s = '0;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (!level_r) begin
          state_s = ST_IDLE;
          timer_s = '0;
        end else if (!REPEAT_EN) begin
          timer_s = '0;
        end else if (timer_r <= ONE_C) begin
          pulse_s = 1'b1;
          timer_s = RATE_C;
          state_s = ST_REPEAT;
        end else begin
          timer_s = timer_r - ONE_C;
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = '0;
      end
    endcase
  end

  // FSM, timer and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      timer_r <= '0;
      pulse_r <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      pulse_r <= pulse_s;
    end
  end

  assign level = level_r;
  assign pulse = pulse_r;

endmodule

// File: rtl/halflife_input_cond.sv
// Conditions the up/down/load buttons into clean command pulses for the half-life timer core,
// suppressing contradictory up+down commands and giving load priority.
module halflife_input_cond
  import halflife_pkg::*;
#(
  parameter int DEBOUNCE     = DEF_DEBOUNCE,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic up_raw,
  input  logic down_raw,
  input  logic load_raw,
  output logic up_pulse,
  output logic down_pulse,
  output logic load_pulse,
  output logic up_level,
  output logic down_level,
  output logic load_level
);

  logic up_lvl_s;
  logic up_pls_s;
  logic dn_lvl_s;
  logic dn_pls_s;
  logic ld_lvl_s;
  logic ld_pls_s;
  logic both_s;

  halflife_btn_chan #(
    .DEBOUNCE    (DEBOUNCE),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .CNT_W       (CNT_W),
    .REPEAT_EN   (1'b1)
  ) u_up (
    .clk  (clk),
    .reset(reset),
    .raw  (up_raw),
    .level(up_lvl_s),
    .pulse(up_pls_s)
  );

  halflife_btn_chan #(
    .DEBOUNCE    (DEBOUNCE),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .CNT_W       (CNT_W),
    .REPEAT_EN   (1'b1)
  ) u_down (
    .clk  (clk),
    .reset(reset),
    .raw  (down_raw),
    .level(dn_lvl_s),
    .pulse(dn_pls_s)
  );

  halflife_btn_chan #(
    .DEBOUNCE    (DEBOUNCE),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .CNT_W       (CNT_W),
    .REPEAT_EN   (1'b0)
  ) u_load (
    .clk  (clk),
    .reset(reset),
    .raw  (load_raw),
    .level(ld_lvl_s),
    .pulse(ld_pls_s)
  );

  // Arbitration gates only flop outputs, so the command pulses stay glitch-free and aligned with the levels.
  always_comb begin
    both_s     = up_lvl_s & dn_lvl_s;
    load_pulse = ld_pls_s;
    up_pulse   = up_pls_s & ~both_s & ~ld_pls_s;
    down_pulse = dn_pls_s & ~both_s & ~ld_pls_s;
    up_level   = up_lvl_s;
    down_level = dn_lvl_s;
    load_level = ld_lvl_s;
  end

endmodule

// File: tb/tb_halflife_input_cond.sv
// Self-checking bench: directed scenarios plus random button activity against a window-based model.
module tb_halflife_input_cond;

  localparam int DEB   = 4;
  localparam int RDLY  = 10;
  localparam int RRATE = 5;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic reset;
  logic up_raw, down_raw, load_raw;
  logic up_pulse, down_pulse, load_pulse;
  logic up_level, down_level, load_level;

  always #5 clk = ~clk;

  halflife_input_cond #(
    .DEBOUNCE(DEB), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .up_raw(up_raw), .down_raw(down_raw), .load_raw(load_raw),
    .up_pulse(up_pulse), .down_pulse(down_pulse), .load_pulse(load_pulse),
    .up_level(up_level), .down_level(down_level), .load_level(load_level)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_edge = 0;

  // Model: raw samples since reset; a level flips once DEB+1 consecutive synchronised
  // samples (raw delayed two edges) disagree with it, all taken after the previous flip.
  bit hist [3][0:8191];
  int last_flip [3];
  bit lvl_m [3];
  int rise_e [3];
  bit pls_m [3];
  bit exp_up, exp_dn, exp_ld;

  int s0;
  int up_rise;
  int up_q[$];
  int dn_q[$];
  int ld_q[$];

  function automatic bit s2_at(int c, int j);
    return (j >= 2) ? hist[c][j-2] : 1'b0;
  endfunction

  task automatic model_clear();
    n_edge = 0;
    for (int c = 0; c < 3; c++) begin
      lvl_m[c] = 1'b0;
      last_flip[c] = -1;
      rise_e[c] = -100;
      pls_m[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit u, input bit d, input bit l);
    bit rv [3];
    bit both;
    rv[0] = u; rv[1] = d; rv[2] = l;
    for (int c = 0; c < 3; c++) begin
      int k;
      bit all_diff;
      hist[c][n_edge] = rv[c];
      pls_m[c] = 1'b0;
      if (lvl_m[c]) begin
        k = n_edge - rise_e[c] - 1;
        if (k == 0) pls_m[c] = 1'b1;
        if (c != 2 && (k == RDLY || (k > RDLY && (k - RDLY) % RRATE == 0))) pls_m[c] = 1'b1;
      end
      if (n_edge - DEB >= 0 && n_edge - DEB > last_flip[c]) begin
        all_diff = 1'b1;
        for (int j = n_edge - DEB; j <= n_edge; j++)
          if (s2_at(c, j) == lvl_m[c]) all_diff = 1'b0;
        if (all_diff) begin
          lvl_m[c] = ~lvl_m[c];
          last_flip[c] = n_edge;
          if (lvl_m[c]) rise_e[c] = n_edge;
        end
      end
    end
    both   = lvl_m[0] & lvl_m[1];
    exp_ld = pls_m[2];
    exp_up = pls_m[0] & ~both & ~exp_ld;
    exp_dn = pls_m[1] & ~both & ~exp_ld;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n_edge, obs, exp_v);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs == exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_up_pulse"},   up_pulse,   1'b0);
    chk({tag, "_down_pulse"}, down_pulse, 1'b0);
    chk({tag, "_load_pulse"}, load_pulse, 1'b0);
    chk({tag, "_up_level"},   up_level,   1'b0);
    chk({tag, "_down_level"}, down_level, 1'b0);
    chk({tag, "_load_level"}, load_level, 1'b0);
  endtask

  task automatic clr_stats();
    s0 = n_edge;
    up_rise = -1;
    up_q.delete();
    dn_q.delete();
    ld_q.delete();
  endtask

  task automatic step(input bit u, input bit d, input bit l);
    up_raw = u; down_raw = d; load_raw = l;
    @(posedge clk);
    model_edge(u, d, l);
    #1;
    chk("up_level",   up_level,   lvl_m[0]);
    chk("down_level", down_level, lvl_m[1]);
    chk("load_level", load_level, lvl_m[2]);
    chk("up_pulse",   up_pulse,   exp_up);
    chk("down_pulse", down_pulse, exp_dn);
    chk("load_pulse", load_pulse, exp_ld);
    if (up_level === 1'b1 && up_rise < 0) up_rise = n_edge - s0;
    if (up_pulse === 1'b1)   up_q.push_back(n_edge - s0);
    if (down_pulse === 1'b1) dn_q.push_back(n_edge - s0);
    if (load_pulse === 1'b1) ld_q.push_back(n_edge - s0);
    n_edge++;
  endtask

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    int cur [3];
    int rem [3];
    reset = 1'b0; up_raw = 1'b0; down_raw = 1'b0; load_raw = 1'b0;
    #1 reset = 1'b1;
    #1 chk_all_zero("por");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();

    // Clean up press held 30 cycles.
    clr_stats();
    repeat (30) step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk_int("s1_level_rise", up_rise, 6);
    chk_int("s1_first_pulse", qat(up_q, 0), 7);
    chk_int("s1_second_pulse", qat(up_q, 1), 17);
    chk_int("s1_third_pulse", qat(up_q, 2), 22);
    chk_int("s1_pulse_count", up_q.size(), 5);

    // Bouncing down press, then a short steady run.
    clr_stats();
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk_int("s2_down_count", dn_q.size(), 1);
    chk_int("s2_down_first", qat(dn_q, 0), 12);

    // Load and up pressed together: load wins its cycle.
    clr_stats();
    repeat (40) step(1'b1, 1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk_int("s3_load_count", ld_q.size(), 1);
    chk_int("s3_load_first", qat(ld_q, 0), 7);
    chk_int("s3_up_count", up_q.size(), 6);
    chk_int("s3_up_first", qat(up_q, 0), 17);

    // Up and down together, then down released.
    clr_stats();
    repeat (20) step(1'b1, 1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk_int("s4_down_count", dn_q.size(), 0);
    chk_int("s4_up_count", up_q.size(), 4);
    chk_int("s4_up_first", qat(up_q, 0), 27);

    // Reset in the middle of auto-repeat, button kept held.
    clr_stats();
    repeat (25) step(1'b1, 1'b0, 1'b0);
    chk("s5_level_before_reset", up_level, 1'b1);
    reset = 1'b1;
    #1 chk_all_zero("s5_async_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    clr_stats();
    repeat (15) step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk_int("s5_level_rise", up_rise, 6);
    chk_int("s5_first_pulse", qat(up_q, 0), 7);

    // Glitch shorter than the debounce window.
    clr_stats();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (15) step(1'b0, 1'b0, 1'b0);
    chk_int("s6_level_rise", up_rise, -1);
    chk_int("s6_up_count", up_q.size(), 0);

    // Random presses, holds and bounces on all three pins.
    for (int c = 0; c < 3; c++) begin
      cur[c] = 0;
      rem[c] = $urandom_range(1, 30);
    end
    repeat (1500) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          cur[c] = 1 - cur[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
        end
        rem[c]--;
      end
      step(cur[0] != 0, cur[1] != 0, cur[2] != 0);
    end
    repeat (20) step(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
